// File: rtl/wr_ctrl_pkg.sv
// Shared definitions for the skewed write controller: FSM state encoding,
// default geometry and the width of the internal beat counter.
package wr_ctrl_pkg;

  // Default array geometry
  localparam int DEF_WIDTH_HEIGHT = 16;
  localparam int DEF_ADDR_WIDTH   = 8;

  // FSM state type and encodings
  typedef logic [1:0] wr_state_t;
  localparam wr_state_t ST_IDLE = 2'd0;
  localparam wr_state_t ST_RUN  = 2'd1;
  localparam wr_state_t ST_DONE = 2'd2;

  // Beat counter must reach num_rows + WIDTH_HEIGHT - 2 with WIDTH_HEIGHT up
  // to 64 and num_rows up to all-ones, so it needs 7 bits beyond the address.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 7;
  endfunction

endpackage

// File: rtl/wr_col_lane.sv
// One column of the skewed write pattern: column COL is enabled for beats
// COL .. COL+num_rows-1 and writes base_addr + (t - COL), wrapping modulo
// 2^ADDR_WIDTH. Purely combinational; the top registers the result.
module wr_col_lane
  import wr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_W      = cnt_width(DEF_ADDR_WIDTH),
  parameter int COL        = 0
) (
  input  logic                  active,
  input  logic [CNT_W-1:0]      t,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_rows,
  output logic                  en,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [CNT_W-1:0]      COL_C = CNT_W'(COL);
  // Address offset only needs the low bits since the sum wraps anyway
  localparam logic [ADDR_WIDTH-1:0] COL_A = ADDR_WIDTH'(COL);

  logic [CNT_W-1:0] rows_ext;
  logic             in_window;

  // Diagonal window test and wrapped address for this column
  always_comb begin
    rows_ext  = CNT_W'(num_rows);
    in_window = (t >= COL_C) && (t < (COL_C + rows_ext));
    en        = active && in_window;
    addr      = en ? (base_addr + t[ADDR_WIDTH-1:0] - COL_A) : '0;
  end

endmodule

// File: rtl/wr_skew_control.sv
// Skewed (diagonal) write controller for a WIDTH_HEIGHT-column array.
// A start in IDLE latches base_addr/num_rows and runs beats t = 0 ..
// num_rows+WIDTH_HEIGHT-2; column i writes during beats i .. i+num_rows-1.
// A one-cycle DONE (done=1) follows, then IDLE. All outputs are registered:
// the next-cycle values are computed from next-state signals and captured.
//
// Optional feature: define WR_SKEW_CTRL_STALL_EN to add the stall input.
// A stall sampled in RUN inserts a bubble (wr_en=0, wr_addr=0) and holds
// the beat counter, so no beat is lost when stall falls.
module wr_skew_control
  import wr_ctrl_pkg::*;
#(
  parameter int WIDTH_HEIGHT = DEF_WIDTH_HEIGHT,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [ADDR_WIDTH-1:0]              num_rows,
`ifdef WR_SKEW_CTRL_STALL_EN
  input  logic                               stall,
`endif
  output logic                               busy,
  output logic                               done,
  output logic [WIDTH_HEIGHT-1:0]            wr_en,
  output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] wr_addr
);

  localparam int               CNT_W    = cnt_width(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] LAST_OFS = CNT_W'(WIDTH_HEIGHT - 2);

  // Registered state
  wr_state_t             state;
  logic [CNT_W-1:0]      t_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] rows_q;

  // Next-state values
  wr_state_t             state_nxt;
  logic [CNT_W-1:0]      t_nxt;
  logic [ADDR_WIDTH-1:0] base_nxt;
  logic [ADDR_WIDTH-1:0] rows_nxt;
  logic                  issue;      // next cycle carries a beat
  logic [CNT_W-1:0]      last_beat;

  logic [WIDTH_HEIGHT-1:0]            en_nxt;
  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] addr_nxt;

  // FSM next state, beat counter advance and parameter capture
  always_comb begin
    state_nxt = state;
    t_nxt     = t_q;
    base_nxt  = base_q;
    rows_nxt  = rows_q;
    issue     = 1'b0;
    last_beat = CNT_W'(rows_q) + LAST_OFS;
    case (state)
      ST_IDLE: begin
        if (start) begin
          base_nxt = base_addr;
          rows_nxt = num_rows;
          t_nxt    = '0;
          if (num_rows != '0) begin
            state_nxt = ST_RUN;
            issue     = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        // t_q is the last issued beat; a bubble leaves it untouched
`ifdef WR_SKEW_CTRL_STALL_EN
        if (stall) begin
          issue = 1'b0;
        end else
`endif
        if (t_q == last_beat) begin
          state_nxt = ST_DONE;
          t_nxt     = '0;
        end else begin
          t_nxt = t_q + 1'b1;
          issue = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // One lane per column evaluates the next-cycle enable and address
  for (genvar i = 0; i < WIDTH_HEIGHT; i++) begin : g_lane
    wr_col_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .CNT_W      (CNT_W),
      .COL        (i)
    ) u_lane (
      .active    (issue),
      .t         (t_nxt),
      .base_addr (base_nxt),
      .num_rows  (rows_nxt),
      .en        (en_nxt[i]),
      .addr      (addr_nxt[i*ADDR_WIDTH +: ADDR_WIDTH])
    );
  end

  // State and registered outputs; reset aborts any sequence silently
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      t_q     <= '0;
      base_q  <= '0;
      rows_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= '0;
      wr_addr <= '0;
    end else begin
      state   <= state_nxt;
      t_q     <= t_nxt;
      base_q  <= base_nxt;
      rows_q  <= rows_nxt;
      busy    <= (state_nxt == ST_RUN);
      done    <= (state_nxt == ST_DONE);
      wr_en   <= en_nxt;
      wr_addr <= addr_nxt;
    end
  end

endmodule

// File: tb/tb_wr_skew_control.sv
// Bench for wr_skew_control (WIDTH_HEIGHT=4, ADDR_WIDTH=8). Expected cycles
// come from the diagonal write rule applied per beat; define
// WR_SKEW_CTRL_STALL_EN to include the stall scenario.
module tb_wr_skew_control;

  localparam int W  = 4;
  localparam int AW = 8;
  localparam int EW = 2 + W + W*AW;   // {busy, done, wr_en, wr_addr}

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW-1:0]   num_rows = '0;
`ifdef WR_SKEW_CTRL_STALL_EN
  logic            stall = 1'b0;
`endif
  logic            busy;
  logic            done;
  logic [W-1:0]    wr_en;
  logic [W*AW-1:0] wr_addr;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  wr_skew_control #(.WIDTH_HEIGHT(W), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
`ifdef WR_SKEW_CTRL_STALL_EN
    .stall     (stall),
`endif
    .busy      (busy),
    .done      (done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr)
  );

  function automatic logic [EW-1:0] pack(input logic b, input logic d,
                                         input logic [W-1:0] e,
                                         input logic [W*AW-1:0] a);
    return {b, d, e, a};
  endfunction

  // Reference: every cycle of one sequence, then DONE, then one IDLE cycle
  task automatic push_seq(input logic [AW-1:0] base, input logic [AW-1:0] rows);
    logic [W-1:0]    en;
    logic [W*AW-1:0] addr;
    logic [AW-1:0]   a;
    int              n;
    n = (rows == 0) ? 0 : int'(rows) + W - 1;
    for (int t = 0; t < n; t++) begin
      en   = '0;
      addr = '0;
      for (int i = 0; i < W; i++) begin
        if (t >= i && t <= i + int'(rows) - 1) begin
          en[i] = 1'b1;
          a = base + AW'(t - i);
          addr[i*AW +: AW] = a;
        end
      end
      exp_q.push_back(pack(1'b1, 1'b0, en, addr));
    end
    exp_q.push_back(pack(1'b0, 1'b1, '0, '0));
    exp_q.push_back(pack(1'b0, 1'b0, '0, '0));
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [EW-1:0] e);
    logic [EW-1:0] obs;
    obs = {busy, done, wr_en, wr_addr};
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Walk the expected queue one cycle at a time; inputs are scrambled after
  // acceptance to show they were latched
  task automatic drain(input string tag, input bit hold);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      base_addr = AW'($urandom);
      num_rows  = AW'($urandom);
      check(tag, exp_q.pop_front());
    end
  endtask

  // Driver: issue one sequence from a negedge and check it to the end
  task automatic run_seq(input string tag, input logic [AW-1:0] base,
                         input logic [AW-1:0] rows, input bit hold);
    push_seq(base, rows);
    start     = 1'b1;
    base_addr = base;
    num_rows  = rows;
    drain(tag, hold);
    start = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] rb;
    logic [AW-1:0] rr;

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_state", '0);
    reset = 1'b0;
    @(negedge clk);
    check("idle", '0);

    // Basic diagonal, address wrap, zero-row sequence
    run_seq("basic_10_3", 8'h10, 8'd3, 1'b0);
    run_seq("wrap_fe_4", 8'hFE, 8'd4, 1'b0);
    run_seq("zero_rows", 8'h33, 8'd0, 1'b0);

    // Reset in beat 2 with start also high: aborts, no done pulse
    push_seq(8'h10, 8'd3);
    start     = 1'b1;
    base_addr = 8'h10;
    num_rows  = 8'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("abort_pre", exp_q.pop_front());
    end
    exp_q.delete();
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("abort_reset", '0);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", '0);
    end
    run_seq("after_abort", 8'h10, 8'd3, 1'b0);

    // start held high through RUN and DONE must not queue a second run
    run_seq("start_held", 8'h20, 8'd2, 1'b1);
    @(negedge clk);
    check("start_held_idle", '0);

`ifdef WR_SKEW_CTRL_STALL_EN
    // Two bubble cycles after beat 0; pattern resumes at 0011
    push_seq(8'h10, 8'd3);
    start     = 1'b1;
    base_addr = 8'h10;
    num_rows  = 8'd3;
    @(negedge clk);
    start = 1'b0;
    check("stall_beat0", exp_q.pop_front());
    stall = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stall_bubble", pack(1'b1, 1'b0, '0, '0));
    end
    stall = 1'b0;
    drain("stall_resume", 1'b0);
    // stall in IDLE has no effect on acceptance
    stall = 1'b1;
    push_seq(8'h05, 8'd1);
    start     = 1'b1;
    base_addr = 8'h05;
    num_rows  = 8'd1;
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    check("stall_idle", exp_q.pop_front());
    drain("stall_idle_rest", 1'b0);
`endif

    // Randomized sequences
    for (int n = 0; n < 8; n++) begin
      rb = AW'($urandom);
      rr = AW'($urandom_range(0, 9));
      run_seq("random", rb, rr, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wr_skew_control.md
WR_SKEW_CONTROL -- requirements
Module: wr_skew_control

Interface
REQ-001 Parameter WIDTH_HEIGHT, default 16, is the number of array columns and the number of write-enable lanes (legal range 2..64).
REQ-002 Parameter ADDR_WIDTH, default 8, is the per-column memory address width.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request to begin one write sequence; sampled only in IDLE.
REQ-006 Port base_addr, input, ADDR_WIDTH bits: first address written by every column; captured when start is accepted.
REQ-007 Port num_rows, input, ADDR_WIDTH bits: number of writes per column; captured when start is accepted.
REQ-008 Port busy, output, 1 bit: high while a sequence is in progress.
REQ-009 Port done, output, 1 bit: single-cycle completion pulse.
REQ-010 Port wr_en, output, WIDTH_HEIGHT bits: per-column write enable; bit i drives column i.
REQ-011 Port wr_addr, output, WIDTH_HEIGHT*ADDR_WIDTH bits: per-column address; column i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 Port stall, input, 1 bit: freezes the sequence; present only under WR_SKEW_CTRL_STALL_EN.

Function
REQ-013 FSM states: IDLE, RUN, DONE; all outputs are registered.
REQ-014 IDLE->RUN when start=1 and num_rows!=0; IDLE->DONE when start=1 and num_rows=0; base_addr and num_rows are latched on that edge.
REQ-015 In RUN, cycle counter t starts at 0 in the first RUN cycle and increments by 1 per non-stalled cycle.
REQ-016 wr_en[i]=1 exactly when i <= t <= i+num_rows-1 (diagonal skew: ramp-up, steady state, ramp-down).
REQ-017 When wr_en[i]=1, wr_addr column i = base_addr + (t - i), computed modulo 2^ADDR_WIDTH; wrap-around past all-ones is legal and silent.
REQ-018 When wr_en[i]=0, wr_addr column i is 0.
REQ-019 RUN->DONE after cycle t = num_rows+WIDTH_HEIGHT-2, the last cycle with any wr_en bit set.
REQ-020 DONE lasts one cycle with done=1 and busy=0, then the FSM returns to IDLE.
REQ-021 busy=1 in every RUN cycle, and 0 otherwise.
REQ-022 Latency: start accepted at edge N gives wr_en[0]=1 during cycle N+1; a full sequence takes num_rows+WIDTH_HEIGHT-1 RUN cycles plus 1 DONE cycle.
REQ-023 start is ignored in RUN and DONE; a start asserted in the DONE cycle is not queued.
REQ-024 num_rows=0 produces no wr_en activity and exactly one done pulse, in the cycle after acceptance.

Reset
REQ-025 reset=1 at any edge, including mid-RUN, forces IDLE and makes wr_en=0, wr_addr=0, busy=0, done=0, t=0 and the latched base_addr and num_rows 0.
REQ-026 reset overrides start and stall in the same cycle; no done pulse is produced for an aborted sequence.

Configuration
REQ-027 With macro WR_SKEW_CTRL_STALL_EN defined, the stall port exists; stall=1 in RUN forces wr_en=0 and wr_addr=0 the next cycle, freezes t, and the sequence resumes unchanged when stall falls.
REQ-028 stall has no effect in IDLE or DONE.
REQ-029 With WR_SKEW_CTRL_STALL_EN undefined, the stall port and all stall logic are absent, and behaviour equals that of stall tied to 0.

Structure
REQ-030 Package wr_ctrl_pkg holds the FSM state typedef (IDLE/RUN/DONE) and the default-parameter constants.
REQ-031 One sub-module, wr_col_lane, is instantiated per column; it computes that column's enable and address from t, its column index, base_addr and num_rows.

Verification
REQ-032 WIDTH_HEIGHT=4, base_addr=0x10, num_rows=3 -> wr_en sequence 0001,0011,0111,1110,1100,1000; column 3 addresses 0x10,0x11,0x12; done pulses 1 cycle after the 1000 cycle.
REQ-033 base_addr=0xFE, num_rows=4, ADDR_WIDTH=8 -> column 0 writes addresses 0xFE,0xFF,0x00,0x01.
REQ-034 num_rows=0 with start=1 -> wr_en never set, busy stays 0, exactly one done pulse.
REQ-035 reset asserted at t=2 of the REQ-032 run -> the next cycle has all outputs 0 and no done pulse; a new start then runs normally.
REQ-036 With WR_SKEW_CTRL_STALL_EN, stall high for 2 cycles at t=1 -> wr_en=0 for 2 cycles, then the REQ-032 pattern resumes from 0011 and the total RUN length grows by 2.
REQ-037 start held high in RUN and in DONE -> no second sequence begins until start is sampled in IDLE.
